// File: rtl/lc3b_types.sv
// Purpose : shared LC-3b datapath types and the memory responder's FSM encoding.
// Latency : n/a (type definitions only).
// Backpressure: n/a.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    mem_idle,
    mem_busy,
    mem_resp
  } lc3b_mem_state;

  // Largest response latency the counter is sized for.
  localparam int lc3b_mem_max_delay = 15;

endpackage

// File: rtl/lc3b_mem_array.sv
// Purpose : 2^ADDR_W x 16 synchronous storage, per-byte write enables, registered read port.
// Latency : read data appears one edge after rd_en; writes commit on the same edge.
// Backpressure: none; accepts an access every cycle.
//
// Ports:
//   clk, reset        - clock; reset clears only the read register, never the storage
//   rd_en             - load rdata from word addr on this edge
//   wr_en, wmask      - write enable; wmask[1] = high byte, wmask[0] = low byte
//   addr, wdata       - word address and write data
//   rdata             - registered read data, holds between reads
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  lc3b_mem_wmask     wmask,
  input  logic [ADDR_W-1:0] addr,
  input  lc3b_word          wdata,
  output lc3b_word          rdata
);

  lc3b_word mem_q [2**ADDR_W];
  lc3b_word rdata_q;
  lc3b_word rdata_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wmask[1]) mem_q[addr][15:8] <= wdata[15:8];
      if (wmask[0]) mem_q[addr][7:0]  <= wdata[7:0];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// Purpose : word memory answering LC-3b mem_read/mem_write with a fixed latency and byte mask.
// Latency : mem_resp pulses DELAY cycles after the request is seen in IDLE (DELAY in 1..15).
// Backpressure: requests are level-held by the initiator; new ones are only accepted in IDLE.
//
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   mem_read, mem_write       - level requests held until mem_resp
//   mem_address               - byte address, bits [ADDR_W:1] select the word
//   mem_wdata, mem_wmask      - write data and byte enables
//   mem_rdata                 - last read data (registered)
//   mem_resp                  - one-cycle completion pulse (registered)
//   mem_err                   - sticky protocol-violation flag, cleared only by reset
module lc3b_mem_responder
  import lc3b_types::lc3b_word, lc3b_types::lc3b_mem_wmask, lc3b_types::lc3b_mem_state;
#(
  parameter int ADDR_W = 8,
  parameter int DELAY  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_wmask,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          mem_err
);

  localparam int CNT_W = $clog2(lc3b_types::lc3b_mem_max_delay + 1);
  localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lc3b_mem_state    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  lc3b_word         addr_q, addr_d;
  lc3b_word         wdata_q, wdata_d;
  lc3b_mem_wmask    wmask_q, wmask_d;
  logic             err_q, err_d;

  logic              arr_rd_en;
  logic              arr_wr_en;
  logic [ADDR_W-1:0] arr_addr;
  lc3b_word          arr_wdata;
  lc3b_mem_wmask     arr_wmask;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    err_d     = err_q;
    arr_rd_en = 1'b0;
    arr_wr_en = 1'b0;
    arr_addr  = addr_q[ADDR_W:1];
    arr_wdata = wdata_q;
    arr_wmask = wmask_q;

    case (state_q)
      lc3b_types::mem_idle: begin
        if (mem_read || mem_write) begin
          rd_d    = mem_read;
          wr_d    = mem_write;   // read+write together is served as a write
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          wmask_d = mem_wmask;
          if (mem_read && mem_write) err_d = 1'b1;
          if (DELAY == 1) begin
            // No BUSY phase: the access happens on this edge from the live inputs.
            state_d   = lc3b_types::mem_resp;
            cnt_d     = '0;
            arr_addr  = mem_address[ADDR_W:1];
            arr_wdata = mem_wdata;
            arr_wmask = mem_wmask;
            arr_wr_en = mem_write;
            arr_rd_en = !mem_write;
          end else begin
            state_d = lc3b_types::mem_busy;
            cnt_d   = DELAY_M1;
          end
        end
      end

      lc3b_types::mem_busy: begin
        cnt_d = cnt_q - CNT_ONE;
        // The initiator must hold its request stable; flag any change but keep serving the latched one.
        if ((mem_read != rd_q) || (mem_write != wr_q) || (mem_address != addr_q) ||
            (wr_q && ((mem_wdata != wdata_q) || (mem_wmask != wmask_q))))
          err_d = 1'b1;
        // Counter reaches zero on this edge, so the access commits as RESP is entered.
        if (cnt_q == CNT_ONE) begin
          state_d   = lc3b_types::mem_resp;
          arr_wr_en = wr_q;
          arr_rd_en = !wr_q;
        end
      end

      lc3b_types::mem_resp: begin
        state_d = lc3b_types::mem_idle;
      end

      default: begin
        state_d = lc3b_types::mem_idle;
      end
    endcase

    // A reset edge aborts any in-flight access so the array is never touched.
    if (reset) begin
      arr_rd_en = 1'b0;
      arr_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= lc3b_types::mem_idle;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      err_q   <= err_d;
    end
  end

  lc3b_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .rd_en (arr_rd_en),
    .wr_en (arr_wr_en),
    .wmask (arr_wmask),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (mem_rdata)
  );

  assign mem_resp = (state_q == lc3b_types::mem_resp);
  assign mem_err  = err_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;

  localparam int DLY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] mem_address = '0, mem_wdata = '0;
  logic [1:0]  mem_wmask = '0;
  logic [15:0] mem_rdata;
  logic        mem_resp, mem_err;

  logic        mem_read_1 = 1'b0, mem_write_1 = 1'b0;
  logic [15:0] mem_address_1 = '0, mem_wdata_1 = '0;
  logic [1:0]  mem_wmask_1 = '0;
  logic [15:0] mem_rdata_1;
  logic        mem_resp_1, mem_err_1;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: plain word array plus expected output registers.
  logic [15:0] model_mem [256];
  logic [15:0] exp_rdata = '0;
  bit          exp_err   = 1'b0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_W(8), .DELAY(DLY)) dut (
    .clk(clk), .reset(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err)
  );

  lc3b_mem_responder #(.ADDR_W(8), .DELAY(1)) dut1 (
    .clk(clk), .reset(rst),
    .mem_read(mem_read_1), .mem_write(mem_write_1),
    .mem_address(mem_address_1), .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1),
    .mem_rdata(mem_rdata_1), .mem_resp(mem_resp_1), .mem_err(mem_err_1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] m);
    logic [7:0] idx;
    idx = a[8:1];
    if (m[1]) model_mem[idx][15:8] = wd[15:8];
    if (m[0]) model_mem[idx][7:0]  = wd[7:0];
  endtask

  // One full transaction on the DELAY=3 instance, checked against the model.
  task automatic xact(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [1:0] m);
    int lat;
    bit got;
    logic [15:0] ra;
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_wmask = m;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) got = 1;
    end
    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(DLY));
    mem_read = 1'b0; mem_write = 1'b0;
    if (wr) begin
      model_write(a, wd, m);
      if (rd) exp_err = 1'b1;
    end else begin
      ra = a;
      exp_rdata = model_mem[ra[8:1]];
    end
    check("rdata", 32'(mem_rdata), 32'(exp_rdata));
    check("err", 32'(mem_err), 32'(exp_err));
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(mem_resp), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    check("rst_resp", 32'(mem_resp), 32'd0);
    check("rst_rdata", 32'(mem_rdata), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
  endtask

  initial begin
    int lat, nresp, last;
    bit got;
    logic [15:0] a;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Read of a preloaded word at byte address 0x0010 (word 8)
    xact(0, 1, 16'h0010, 16'hBEEF, 2'b11);
    xact(1, 0, 16'h0010, 16'h0000, 2'b00);
    check("beef_read", 32'(mem_rdata), 32'h0000BEEF);

    // Byte masks
    xact(0, 1, 16'h0020, 16'hFFFF, 2'b11);
    xact(0, 1, 16'h0020, 16'h1234, 2'b01);
    xact(1, 0, 16'h0020, 16'h0000, 2'b00);
    check("wmask_lo", 32'(mem_rdata), 32'h0000FF34);
    xact(0, 1, 16'h0020, 16'h1234, 2'b10);
    xact(1, 0, 16'h0020, 16'h0000, 2'b00);
    check("wmask_hi", 32'(mem_rdata), 32'h00001234);
    xact(0, 1, 16'h0020, 16'hABCD, 2'b00);
    xact(1, 0, 16'h0020, 16'h0000, 2'b00);
    check("wmask_none", 32'(mem_rdata), 32'h00001234);

    // Fill every word (aliased upper address bits) so random reads are predictable
    for (int i = 0; i < 256; i++) begin
      a = 16'($urandom);
      a[8:1] = 8'(i);
      xact(0, 1, a, 16'($urandom), 2'b11);
    end

    // Randomized reads and writes
    for (int i = 0; i < 150; i++) begin
      bit wr;
      wr = ($urandom_range(0, 1) == 1);
      xact(!wr, wr, 16'($urandom), 16'($urandom), 2'($urandom));
    end

    // Read and write together: served as a write, sticky error
    xact(1, 1, 16'h0004, 16'hA5A5, 2'b11);
    xact(1, 0, 16'h0004, 16'h0000, 2'b00);
    check("both_write_data", 32'(mem_rdata), 32'h0000A5A5);
    check("both_err_sticky", 32'(mem_err), 32'd1);
    xact(0, 1, 16'h0008, 16'h0101, 2'b11);
    do_reset();

    // Reset in the second BUSY cycle aborts the write
    xact(0, 1, 16'h0006, 16'h0000, 2'b11);
    do_reset();
    mem_write = 1'b1; mem_address = 16'h0006; mem_wdata = 16'h5555; mem_wmask = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_resp", 32'(mem_resp), 32'd0);
    check("abort_rdata", 32'(mem_rdata), 32'd0);
    nresp = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_resp) nresp++;
    end
    check("abort_no_resp", 32'(nresp), 32'd0);
    xact(1, 0, 16'h0006, 16'h0000, 2'b00);
    check("abort_array", 32'(mem_rdata), 32'd0);

    // Address changed mid-BUSY: latched address wins, error flagged
    xact(0, 1, 16'h0030, 16'h1111, 2'b11);
    xact(0, 1, 16'h0040, 16'h2222, 2'b11);
    mem_read = 1'b1; mem_address = 16'h0030;
    @(posedge clk); #1;
    mem_address = 16'h0040;
    lat = 1; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) got = 1;
    end
    mem_read = 1'b0;
    check("chg_latency", 32'(lat), 32'(DLY));
    check("chg_rdata", 32'(mem_rdata), 32'h00001111);
    check("chg_err", 32'(mem_err), 32'd1);
    @(posedge clk); #1;
    do_reset();

    // DELAY=1 instance: write, then a read held high through every RESP
    mem_write_1 = 1'b1; mem_address_1 = 16'h0002; mem_wdata_1 = 16'h3C3C; mem_wmask_1 = 2'b11;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp_1) got = 1;
    end
    check("d1_latency", 32'(lat), 32'd1);
    mem_write_1 = 1'b0;
    @(posedge clk); #1;
    mem_read_1 = 1'b1;
    nresp = 0; last = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (mem_resp_1) begin
        nresp++;
        check("d1_rdata", 32'(mem_rdata_1), 32'h00003C3C);
        if (last >= 0) check("d1_spacing", 32'(c - last), 32'd2);
        last = c;
      end
    end
    mem_read_1 = 1'b0;
    check("d1_pulses", 32'(nresp), 32'd6);
    check("d1_err", 32'(mem_err_1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
